// File: rtl/mem_stage_if.sv
// Memory-stage bus: one outstanding request held until a single-cycle ack strobe.
interface mem_stage_if;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_ack;
    logic [15:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU results through, or stalls upstream while a
// load/store runs on the bus with a bounded wait for the ack.
module mem_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [3:0]  waddr_i,
    input  logic [15:0] wdata_i,
    input  logic [1:0]  memrw_i,
    input  logic [15:0] memaddr_i,
    input  logic [15:0] memdata_i,
    mem_stage_if.master bus,
    output logic        we_o,
    output logic [3:0]  waddr_o,
    output logic [15:0] wdata_o,
    output logic        stallreq,
    output logic        err_o
);

    localparam logic [7:0] TimeoutC = 8'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [15:0] addr_q;
    logic [15:0] mdata_q;
    logic        is_wr_q;
    logic        lwe_q;
    logic [3:0]  lwaddr_q;
    logic [15:0] lwdata_q;

    logic mem_op;
    logic timeout_hit;

    always_comb begin
        mem_op        = (memrw_i == 2'b01) || (memrw_i == 2'b10);
        // This BUSY cycle is the TIMEOUT-th one without an ack.
        timeout_hit   = (cnt_q == TimeoutC - 8'd1);
        stallreq      = (state_q == StBusy) || ((state_q == StIdle) && mem_op);
        bus.bus_req   = (state_q == StBusy);
        bus.bus_we    = (state_q == StBusy) && is_wr_q;
        bus.bus_addr  = addr_q;
        bus.bus_wdata = mdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            addr_q   <= 16'd0;
            mdata_q  <= 16'd0;
            is_wr_q  <= 1'b0;
            lwe_q    <= 1'b0;
            lwaddr_q <= 4'd0;
            lwdata_q <= 16'd0;
            we_o     <= 1'b0;
            waddr_o  <= 4'd0;
            wdata_o  <= 16'd0;
            err_o    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    err_o <= 1'b0;
                    if (mem_op) begin
                        addr_q   <= memaddr_i;
                        mdata_q  <= memdata_i;
                        is_wr_q  <= (memrw_i == 2'b10);
                        lwe_q    <= we_i;
                        lwaddr_q <= waddr_i;
                        lwdata_q <= wdata_i;
                        cnt_q    <= 8'd0;
                        we_o     <= 1'b0;
                        state_q  <= StBusy;
                    end else begin
                        we_o    <= we_i;
                        waddr_o <= waddr_i;
                        wdata_o <= wdata_i;
                    end
                end
                StBusy: begin
                    // An ack on the final allowed cycle still wins over the timeout.
                    if (bus.bus_ack) begin
                        we_o    <= lwe_q;
                        waddr_o <= lwaddr_q;
                        wdata_o <= is_wr_q ? lwdata_q : bus.bus_rdata;
                        state_q <= StDone;
                    end else if (timeout_hit) begin
                        we_o    <= 1'b0;
                        err_o   <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StDone: begin
                    we_o    <= 1'b0;
                    err_o   <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    we_o    <= 1'b0;
                    err_o   <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed and random ALU/load/store/timeout/reset sequences
// checked against a transaction-level model of the stage.
module tb_mem_stage;

    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_i = 1'b0;
    logic [3:0]  waddr_i = 4'd0;
    logic [15:0] wdata_i = 16'd0;
    logic [1:0]  memrw_i = 2'b00;
    logic [15:0] memaddr_i = 16'd0;
    logic [15:0] memdata_i = 16'd0;
    logic        we_o;
    logic [3:0]  waddr_o;
    logic [15:0] wdata_o;
    logic        stallreq;
    logic        err_o;

    mem_stage_if bus_if ();

    mem_stage #(.TIMEOUT(T)) dut (
        .clk       (clk),
        .rst       (rst),
        .we_i      (we_i),
        .waddr_i   (waddr_i),
        .wdata_i   (wdata_i),
        .memrw_i   (memrw_i),
        .memaddr_i (memaddr_i),
        .memdata_i (memdata_i),
        .bus       (bus_if),
        .we_o      (we_o),
        .waddr_o   (waddr_o),
        .wdata_o   (wdata_o),
        .stallreq  (stallreq),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Write-back fields the stage is expected to be holding.
    logic [3:0]  m_waddr;
    logic [15:0] m_wdata;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic alu_op(input logic [1:0] rw, input logic we, input logic [3:0] wa,
                          input logic [15:0] wd);
        memrw_i          = rw;
        we_i             = we;
        waddr_i          = wa;
        wdata_i          = wd;
        memaddr_i        = 16'($urandom);
        memdata_i        = 16'($urandom);
        bus_if.bus_ack   = 1'($urandom_range(0, 1));
        bus_if.bus_rdata = 16'($urandom);
        @(negedge clk);
        check("alu stallreq", 16'(stallreq), 16'd0);
        check("alu bus_req", 16'(bus_if.bus_req), 16'd0);
        @(posedge clk); #1;
        m_waddr = wa;
        m_wdata = wd;
        check("alu we_o", 16'(we_o), 16'(we));
        check("alu waddr_o", 16'(waddr_o), 16'(m_waddr));
        check("alu wdata_o", wdata_o, m_wdata);
        check("alu err_o", 16'(err_o), 16'd0);
    endtask

    // delay = number of BUSY cycles before the one carrying the ack.
    task automatic mem_op(input logic [1:0] rw, input logic [15:0] addr, input logic [15:0] md,
                          input logic we, input logic [3:0] wa, input logic [15:0] wd,
                          input int delay, input logic [15:0] rdata);
        int busy;
        bit tout;
        tout = (delay >= int'(T));
        busy = tout ? int'(T) : delay + 1;
        memrw_i          = rw;
        we_i             = we;
        waddr_i          = wa;
        wdata_i          = wd;
        memaddr_i        = addr;
        memdata_i        = md;
        bus_if.bus_ack   = 1'($urandom_range(0, 1));
        bus_if.bus_rdata = 16'($urandom);
        @(negedge clk);
        check("issue stallreq", 16'(stallreq), 16'd1);
        check("issue bus_req", 16'(bus_if.bus_req), 16'd0);
        @(posedge clk); #1;
        check("issue we_o", 16'(we_o), 16'd0);
        check("issue waddr_o", 16'(waddr_o), 16'(m_waddr));
        check("issue wdata_o", wdata_o, m_wdata);
        for (int i = 0; i < busy; i++) begin
            bus_if.bus_ack   = (i == delay);
            bus_if.bus_rdata = (i == delay) ? rdata : 16'($urandom);
            memaddr_i        = 16'($urandom);
            memdata_i        = 16'($urandom);
            wdata_i          = 16'($urandom);
            waddr_i          = 4'($urandom);
            we_i             = 1'($urandom);
            @(negedge clk);
            check("busy bus_req", 16'(bus_if.bus_req), 16'd1);
            check("busy bus_we", 16'(bus_if.bus_we), 16'(rw == 2'b10));
            check("busy bus_addr", bus_if.bus_addr, addr);
            check("busy bus_wdata", bus_if.bus_wdata, md);
            check("busy stallreq", 16'(stallreq), 16'd1);
            check("busy we_o", 16'(we_o), 16'd0);
            check("busy err_o", 16'(err_o), 16'd0);
            @(posedge clk); #1;
        end
        // DONE: upstream shows the original instruction; a stray ack must be ignored.
        memaddr_i        = addr;
        memdata_i        = md;
        wdata_i          = wd;
        waddr_i          = wa;
        we_i             = we;
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 16'($urandom);
        if (!tout) begin
            m_waddr = wa;
            m_wdata = (rw == 2'b10) ? wd : rdata;
        end
        @(negedge clk);
        check("done stallreq", 16'(stallreq), 16'd0);
        check("done bus_req", 16'(bus_if.bus_req), 16'd0);
        check("done bus_we", 16'(bus_if.bus_we), 16'd0);
        check("done err_o", 16'(err_o), 16'(tout));
        check("done we_o", 16'(we_o), 16'(!tout && we));
        check("done waddr_o", 16'(waddr_o), 16'(m_waddr));
        check("done wdata_o", wdata_o, m_wdata);
        @(posedge clk); #1;
        check("post we_o", 16'(we_o), 16'd0);
        check("post err_o", 16'(err_o), 16'd0);
        check("post bus_req", 16'(bus_if.bus_req), 16'd0);
        bus_if.bus_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] rw;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 16'd0;
        m_waddr = 4'd0;
        m_wdata = 16'd0;

        #2 rst = 1'b0;
        #1;
        check("rst we_o", 16'(we_o), 16'd0);
        check("rst waddr_o", 16'(waddr_o), 16'd0);
        check("rst wdata_o", wdata_o, 16'd0);
        check("rst bus_req", 16'(bus_if.bus_req), 16'd0);
        check("rst bus_we", 16'(bus_if.bus_we), 16'd0);
        check("rst bus_addr", bus_if.bus_addr, 16'd0);
        check("rst bus_wdata", bus_if.bus_wdata, 16'd0);
        check("rst err_o", 16'(err_o), 16'd0);
        check("rst stallreq", 16'(stallreq), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;

        alu_op(2'b00, 1'b1, 4'd1, 16'h0009);
        mem_op(2'b01, 16'h8000, 16'h0000, 1'b1, 4'd3, 16'h0000, 1, 16'hBEEF);
        mem_op(2'b10, 16'h0010, 16'h1234, 1'b0, 4'd0, 16'h0000, 0, 16'h0000);
        mem_op(2'b01, 16'h2222, 16'h3333, 1'b1, 4'd6, 16'h4444, 10, 16'hDEAD);
        alu_op(2'b11, 1'b1, 4'd2, 16'h0007);
        // Ack on the very cycle the wait limit is reached still succeeds.
        mem_op(2'b01, 16'h5555, 16'h6666, 1'b1, 4'd9, 16'h7777, int'(T) - 1, 16'hCAFE);
        mem_op(2'b10, 16'hA0A0, 16'h0B0B, 1'b1, 4'd4, 16'h1357, 2, 16'h0000);

        // Reset during the second BUSY cycle.
        memrw_i        = 2'b01;
        memaddr_i      = 16'h4444;
        memdata_i      = 16'h9999;
        we_i           = 1'b1;
        waddr_i        = 4'd7;
        wdata_i        = 16'h1111;
        bus_if.bus_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid bus_req", 16'(bus_if.bus_req), 16'd1);
        #2 rst = 1'b0;
        #1;
        memrw_i = 2'b00;
        we_i    = 1'b0;
        #1;
        check("midrst bus_req", 16'(bus_if.bus_req), 16'd0);
        check("midrst bus_we", 16'(bus_if.bus_we), 16'd0);
        check("midrst bus_addr", bus_if.bus_addr, 16'd0);
        check("midrst bus_wdata", bus_if.bus_wdata, 16'd0);
        check("midrst we_o", 16'(we_o), 16'd0);
        check("midrst waddr_o", 16'(waddr_o), 16'd0);
        check("midrst wdata_o", wdata_o, 16'd0);
        check("midrst stallreq", 16'(stallreq), 16'd0);
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 16'hFFFF;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rel we_o", 16'(we_o), 16'd0);
        check("rel bus_req", 16'(bus_if.bus_req), 16'd0);
        check("rel wdata_o", wdata_o, wdata_i);
        alu_op(2'b00, 1'b1, 4'd5, 16'h00A5);

        for (int n = 0; n < 40; n++) begin
            rw = 2'($urandom);
            if (rw == 2'b01 || rw == 2'b10) begin
                mem_op(rw, 16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom),
                       16'($urandom), int'($urandom_range(0, 6)), 16'($urandom));
            end else begin
                alu_op(rw, 1'($urandom), 4'($urandom), 16'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles to wait for bus_ack before aborting (range 1..255).
REQ-002 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 we_i  in  1  register write enable from exe.
REQ-005 waddr_i  in  4  destination register from exe.
REQ-006 wdata_i  in  16  ALU result from exe.
REQ-007 memrw_i  in  2  access type: 00 none, 01 read, 10 write, 11 reserved (treated as none).
REQ-008 memaddr_i  in  16  memory address; memdata_i  in  16  store data.
REQ-009 bus_req  out  1  bus request; bus_we  out  1  1=write; bus_addr  out  16; bus_wdata  out  16.
REQ-010 bus_ack  in  1  bus completion strobe; bus_rdata  in  16  read data, valid when bus_ack=1.
REQ-011 we_o  out  1; waddr_o  out  4; wdata_o  out  16  registered write-back to wb stage.
REQ-012 stallreq  out  1  holds all upstream stages; err_o  out  1  one-cycle bus-timeout pulse.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 IDLE, memrw_i in {00,11}: each edge loads we_o/waddr_o/wdata_o from we_i/waddr_i/wdata_i (latency 1); stallreq=0.
REQ-015 IDLE, memrw_i in {01,10}: stallreq=1 combinationally; at edge latch memaddr_i, memdata_i, we_i, waddr_i, wdata_i, memrw_i; load we_o=0; go BUSY.
REQ-016 BUSY: bus_req=1, bus_we=(latched memrw==10), bus_addr/bus_wdata=latched values, constant for entire BUSY; stallreq=1; we_o=0.
REQ-017 BUSY with bus_ack=1: at edge, read loads wdata_o=bus_rdata, write loads wdata_o=latched wdata; we_o/waddr_o=latched values; go DONE.
REQ-018 bus_ack while not BUSY SHALL be ignored.
REQ-019 BUSY: 8-bit wait counter cleared on BUSY entry, incremented each BUSY cycle without ack; when count reaches TIMEOUT without ack, at that edge go DONE with we_o=0, err_o=1 for that one DONE cycle.
REQ-020 bus_ack arriving in the same cycle the count reaches TIMEOUT SHALL count as success (no err_o).
REQ-021 DONE: stallreq=0, bus_req=0; all inputs ignored (upstream still shows the completed instruction); at edge load we_o=0 and go IDLE unconditionally.
REQ-022 Minimum memory access occupancy: 3 cycles (IDLE-issue, BUSY with ack, DONE); back-to-back accesses SHALL repeat this sequence with no overlap.
REQ-023 bus_req, bus_we, stallreq, err_o SHALL be 0 outside the states listed above.

Reset
REQ-024 rst=0 SHALL immediately force state IDLE, counter 0, and we_o=0, waddr_o=0, wdata_o=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, err_o=0, independent of clk.
REQ-025 Reset during BUSY SHALL abandon the transaction with no write-back; a later bus_ack SHALL be ignored.
REQ-026 First edge after rst rises SHALL be processed as IDLE.

Verification
REQ-027 ALU pass-through: memrw_i=00, we_i=1, waddr_i=1, wdata_i=16'h0009 -> next edge we_o=1, waddr_o=1, wdata_o=0009, stallreq=0 throughout.
REQ-028 Load, ack after 2 BUSY cycles: memrw_i=01, memaddr_i=16'h8000, waddr_i=3, bus_rdata=16'hBEEF -> bus_req=1/bus_we=0/bus_addr=8000 for 2 cycles, then DONE with we_o=1, waddr_o=3, wdata_o=BEEF, stallreq low only in DONE.
REQ-029 Store: memrw_i=10, memaddr_i=16'h0010, memdata_i=16'h1234, we_i=0, ack on first BUSY cycle -> bus_we=1, bus_wdata=1234 one cycle; DONE with we_o=0; total 3 cycles.
REQ-030 Timeout with TIMEOUT=4, no ack: load -> BUSY 4 cycles, DONE with err_o=1, we_o=0; bus_ack injected afterwards has no effect.
REQ-031 Reset mid-access: drive rst=0 in 2nd BUSY cycle -> bus_req and all outputs 0 immediately, no write-back; after rst=1, memrw_i=00 op passes through normally.
REQ-032 Reserved code: memrw_i=11, we_i=1, wdata_i=16'h0007 -> treated as ALU op, bus_req stays 0, wdata_o=0007 next edge.
